// File: rtl/sb_clk_pkg.sv
// Shared types and defaults for the sideband TX clock burst controller.
package sb_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sb_clk_state_e;

  localparam int unsigned SB_PKT_BITS   = 64;
  localparam int unsigned SB_GAP_BITS   = 32;
  localparam int unsigned SB_PEND_DEPTH = 4;

  // Larger of two values; used to size the shared bit/gap counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sb_clk_gate_icg.sv
// Latch-based clock gate; the only latch in the block, replaceable by a library ICG.
module sb_clk_gate_icg (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Enable latch: transparent while clk is low, cleared asynchronously by reset.
  always_latch begin
    if (!rst_n) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en;
    end
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/sb_tx_clk_burst_ctrl.sv
// Sideband TX forwarded-clock controller: PKT_BITS gated pulses per packet,
// GAP_BITS low cycles after each packet, up to PEND_DEPTH queued requests.
module sb_tx_clk_burst_ctrl
  import sb_clk_pkg::*;
#(
  parameter int unsigned PKT_BITS   = SB_PKT_BITS,
  parameter int unsigned GAP_BITS   = SB_GAP_BITS,
  parameter int unsigned PEND_DEPTH = SB_PEND_DEPTH,
  parameter int unsigned CNT_W      = $clog2(max_u(PKT_BITS, GAP_BITS)),
  parameter int unsigned PEND_W     = $clog2(PEND_DEPTH + 1)
) (
  input  logic              i_pll_clk,
  input  logic              i_rst_n,
  input  logic              i_pkt_valid,
  output logic              o_pkt_ready,
  input  logic              i_flush,
  output logic              o_txcksb,
  output logic              o_ser_en,
  output logic [CNT_W-1:0]  o_bit_idx,
  output logic              o_pkt_done,
  output logic              o_burst_end,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pend_cnt
);

  localparam logic [CNT_W-1:0]  PKT_LAST = CNT_W'(PKT_BITS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_BITS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_DEPTH);

  sb_clk_state_e     state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [PEND_W-1:0] pend_q, pend_n;
  logic              send_entry;
  logic              pkt_done_n;
  logic              burst_end_n;
  logic              accept;
  logic              gate_en;

  logic              ser_en_q;
  logic [CNT_W-1:0]  bit_idx_q;
  logic              pkt_done_q;
  logic              burst_end_q;
  logic              busy_q;

  assign o_pkt_ready = (pend_q < PEND_MAX) & ~i_flush;
  assign accept      = i_pkt_valid & o_pkt_ready;

  // FSM state and bit/gap counter register.
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state, counter and pending-queue decode.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    send_entry  = 1'b0;
    pkt_done_n  = 1'b0;
    burst_end_n = 1'b0;
    pend_n      = pend_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_n    = SEND;
          cnt_n      = '0;
          send_entry = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == PKT_LAST) begin
          state_n    = GAP;
          cnt_n      = '0;
          pkt_done_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_n = '0;
          if (pend_q != '0) begin
            state_n    = SEND;
            send_entry = 1'b1;
          end else begin
            state_n     = IDLE;
            burst_end_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Flush wins over both accept and SEND-entry decrement.
    if (i_flush) begin
      pend_n = '0;
    end else if (accept && !send_entry) begin
      pend_n = pend_q + PEND_W'(1);
    end else if (!accept && send_entry) begin
      pend_n = pend_q - PEND_W'(1);
    end
  end

  // Pending count and registered status outputs.
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q      <= '0;
      ser_en_q    <= 1'b0;
      bit_idx_q   <= '0;
      pkt_done_q  <= 1'b0;
      burst_end_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pend_q      <= pend_n;
      ser_en_q    <= (state_n == SEND);
      bit_idx_q   <= (state_n == SEND) ? cnt_n : '0;
      pkt_done_q  <= pkt_done_n;
      burst_end_q <= burst_end_n;
      busy_q      <= (state_n != IDLE);
    end
  end

  // The latch in the gate holds next_state==SEND through the following cycle,
  // so the gated clock is high for exactly the SEND cycles.
  assign gate_en = (state_n == SEND);

  sb_clk_gate_icg u_icg (
    .clk   (i_pll_clk),
    .rst_n (i_rst_n),
    .en    (gate_en),
    .gclk  (o_txcksb)
  );

  assign o_ser_en    = ser_en_q;
  assign o_bit_idx   = bit_idx_q;
  assign o_pkt_done  = pkt_done_q;
  assign o_burst_end = burst_end_q;
  assign o_busy      = busy_q;
  assign o_pend_cnt  = pend_q;

endmodule

// File: tb/tb_sb_tx_clk_burst_ctrl.sv
// Bench for sb_tx_clk_burst_ctrl: a default instance and a small (8/1/1) instance,
// each compared every cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_sb_tx_clk_burst_ctrl;

  localparam int P0 = 64, G0 = 32, D0 = 4;
  localparam int P1 = 8,  G1 = 1,  D1 = 1;
  localparam int CW0 = $clog2(P0), PW0 = $clog2(D0 + 1);
  localparam int CW1 = $clog2(P1), PW1 = $clog2(D1 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 1'b0, f0 = 1'b0, v1 = 1'b0, f1 = 1'b0;
  logic ready0, txck0, ser0, done0, bend0, busy0;
  logic ready1, txck1, ser1, done1, bend1, busy1;
  logic [CW0-1:0] idx0;
  logic [PW0-1:0] pend0;
  logic [CW1-1:0] idx1;
  logic [PW1-1:0] pend1;

  int n_pass = 0, n_checks = 0;

  always #5 clk = ~clk;

  sb_tx_clk_burst_ctrl #(.PKT_BITS(P0), .GAP_BITS(G0), .PEND_DEPTH(D0)) dut0 (
    .i_pll_clk(clk), .i_rst_n(rst_n), .i_pkt_valid(v0), .o_pkt_ready(ready0),
    .i_flush(f0), .o_txcksb(txck0), .o_ser_en(ser0), .o_bit_idx(idx0),
    .o_pkt_done(done0), .o_burst_end(bend0), .o_busy(busy0), .o_pend_cnt(pend0));

  sb_tx_clk_burst_ctrl #(.PKT_BITS(P1), .GAP_BITS(G1), .PEND_DEPTH(D1)) dut1 (
    .i_pll_clk(clk), .i_rst_n(rst_n), .i_pkt_valid(v1), .o_pkt_ready(ready1),
    .i_flush(f1), .o_txcksb(txck1), .o_ser_en(ser1), .o_bit_idx(idx1),
    .o_pkt_done(done1), .o_burst_end(bend1), .o_busy(busy1), .o_pend_cnt(pend1));

  // Edge monitors: pulse counts and full-width (half period) high pulses.
  int  pulses0 = 0, pulses1 = 0, runts0 = 0, runts1 = 0;
  time rise0 = 0, rise1 = 0;
  always @(posedge txck0) begin pulses0++; rise0 = $time; end
  always @(negedge txck0) if (rst_n && ($time - rise0 != 5)) runts0++;
  always @(posedge txck1) begin pulses1++; rise1 = $time; end
  always @(negedge txck1) if (rst_n && ($time - rise1 != 5)) runts1++;

  // Reference model: position inside a PKT+GAP frame (-1 = idle) plus queue depth.
  int pkt_p [2] = '{P0, P1};
  int gap_p [2] = '{G0, G1};
  int dep_p [2] = '{D0, D1};
  int m_pos [2] = '{-1, -1};
  int m_pend[2] = '{0, 0};
  bit m_bend[2] = '{1'b0, 1'b0};

  function automatic void model_edge(input int d, input logic v, input logic f);
    int frame;
    bit last, start, acc;
    if (!rst_n) begin
      m_pos[d] = -1; m_pend[d] = 0; m_bend[d] = 1'b0;
      return;
    end
    frame = pkt_p[d] + gap_p[d];
    last  = (m_pos[d] == frame - 1);
    start = (m_pend[d] > 0) && ((m_pos[d] < 0) || last);
    acc   = v && (m_pend[d] < dep_p[d]) && !f;
    m_bend[d] = last && (m_pend[d] == 0);
    if (start) m_pos[d] = 0;
    else if ((m_pos[d] < 0) || last) m_pos[d] = -1;
    else m_pos[d] = m_pos[d] + 1;
    m_pend[d] = f ? 0 : m_pend[d] + int'(acc) - int'(start);
  endfunction

  // Expected {ready, busy, ser_en, pkt_done, burst_end, txcksb-high-phase}.
  function automatic logic [5:0] exp_flags(input int d, input logic f);
    bit ser;
    ser = (m_pos[d] >= 0) && (m_pos[d] < pkt_p[d]);
    return {(m_pend[d] < dep_p[d]) && !f, m_pos[d] >= 0, ser,
            m_pos[d] == pkt_p[d], m_bend[d], ser};
  endfunction

  function automatic int exp_idx(input int d);
    return ((m_pos[d] >= 0) && (m_pos[d] < pkt_p[d])) ? m_pos[d] : 0;
  endfunction

  // Per-cycle scoreboard, sampled in the clock-high phase.
  always @(posedge clk) begin
    model_edge(0, v0, f0);
    model_edge(1, v1, f1);
    #2;
    n_checks++;
    if ({ready0, busy0, ser0, done0, bend0, txck0} !== exp_flags(0, f0))
      $display("FAIL flags0 t=%0t got=%b want=%b", $time,
               {ready0, busy0, ser0, done0, bend0, txck0}, exp_flags(0, f0));
    else n_pass++;
    n_checks++;
    if (int'(idx0) !== exp_idx(0)) $display("FAIL bit_idx0 t=%0t got=%0d want=%0d", $time, idx0, exp_idx(0));
    else n_pass++;
    n_checks++;
    if (int'(pend0) !== m_pend[0]) $display("FAIL pend0 t=%0t got=%0d want=%0d", $time, pend0, m_pend[0]);
    else n_pass++;
    n_checks++;
    if ({ready1, busy1, ser1, done1, bend1, txck1} !== exp_flags(1, f1))
      $display("FAIL flags1 t=%0t got=%b want=%b", $time,
               {ready1, busy1, ser1, done1, bend1, txck1}, exp_flags(1, f1));
    else n_pass++;
    n_checks++;
    if (int'(idx1) !== exp_idx(1)) $display("FAIL bit_idx1 t=%0t got=%0d want=%0d", $time, idx1, exp_idx(1));
    else n_pass++;
    n_checks++;
    if (int'(pend1) !== m_pend[1]) $display("FAIL pend1 t=%0t got=%0d want=%0d", $time, pend1, m_pend[1]);
    else n_pass++;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({ready0, busy0, ser0, done0, bend0, txck0, idx0, pend0} !== {6'b100000, CW0'(0), PW0'(0)})
      $display("FAIL reset0 got=%b want ready=1 rest 0", {ready0, busy0, ser0, done0, bend0, txck0});
    else n_pass++;
    n_checks++;
    if ({ready1, busy1, ser1, done1, bend1, txck1, idx1, pend1} !== {6'b100000, CW1'(0), PW1'(0)})
      $display("FAIL reset1 got=%b want ready=1 rest 0", {ready1, busy1, ser1, done1, bend1, txck1});
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single();
    int p, done_c, bend_c;
    p = pulses0; done_c = -1; bend_c = -1;
    @(posedge clk); #1 v0 = 1'b1; #1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1 v0 = 1'b0; #1;
      if (c == 1) begin
        n_checks++;
        if (pend0 !== PW0'(1)) $display("FAIL single_pend got=%0d want=1", pend0); else n_pass++;
      end
      if (c == 98) begin
        n_checks++;
        if (busy0 !== 1'b0) $display("FAIL single_busy98 got=%b want=0", busy0); else n_pass++;
      end
      if (done0 && done_c < 0) done_c = c;
      if (bend0 && bend_c < 0) bend_c = c;
    end
    n_checks++;
    if (done_c != 66) $display("FAIL single_done_cycle got=%0d want=66", done_c); else n_pass++;
    n_checks++;
    if (bend_c != 98) $display("FAIL single_bend_cycle got=%0d want=98", bend_c); else n_pass++;
    n_checks++;
    if (pulses0 - p != 64) $display("FAIL single_pulses got=%0d want=64", pulses0 - p); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p, ndone, nbend, bend_c;
    p = pulses0; ndone = 0; nbend = 0; bend_c = -1;
    @(posedge clk); #1 v0 = 1'b1; #1;
    for (int c = 1; c <= 310; c++) begin
      @(posedge clk); #1 v0 = (c <= 2); #1;
      if (done0) ndone++;
      if (bend0) begin nbend++; bend_c = c; end
      if (c == 97 || c == 98 || c == 194) begin
        n_checks++;
        if (ser0 !== (c != 97)) $display("FAIL b2b_ser_c%0d got=%b want=%b", c, ser0, c != 97);
        else n_pass++;
      end
    end
    n_checks++;
    if (ndone != 3) $display("FAIL b2b_done_count got=%0d want=3", ndone); else n_pass++;
    n_checks++;
    if (nbend != 1 || bend_c != 290) $display("FAIL b2b_bend got=%0d@%0d want=1@290", nbend, bend_c);
    else n_pass++;
    n_checks++;
    if (pulses0 - p != 192) $display("FAIL b2b_pulses got=%0d want=192", pulses0 - p); else n_pass++;
  endtask

  task automatic test_full_queue();
    int p, acc;
    p = pulses0; acc = 0;
    @(posedge clk); #1 v0 = 1'b1; #1;
    for (int c = 1; c <= 99; c++) begin
      @(posedge clk); #1 v0 = ((c >= 10 && c <= 15) || c == 98); #1;
      if (c >= 10 && c <= 15 && ready0) acc++;
      if (c == 14) begin
        n_checks++;
        if ({pend0, ready0} !== {PW0'(4), 1'b0}) $display("FAIL full_at_max got=%0d/%b want=4/0", pend0, ready0);
        else n_pass++;
      end
      if (c == 98) begin
        n_checks++;
        if ({pend0, ready0} !== {PW0'(3), 1'b1}) $display("FAIL full_resume got=%0d/%b want=3/1", pend0, ready0);
        else n_pass++;
      end
      if (c == 99) begin
        n_checks++;
        if (pend0 !== PW0'(4)) $display("FAIL full_refill got=%0d want=4", pend0); else n_pass++;
      end
    end
    for (int c = 100; c < 700; c++) begin
      @(posedge clk); #2;
      if (!busy0) break;
    end
    n_checks++;
    if (acc != 4) $display("FAIL full_accepts got=%0d want=4", acc); else n_pass++;
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL full_drain got busy=%b want=0", busy0); else n_pass++;
    n_checks++;
    if (pulses0 - p != 384) $display("FAIL full_pulses got=%0d want=384", pulses0 - p); else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_flush();
    int p, bend_c;
    p = pulses0; bend_c = -1;
    @(posedge clk); #1 v0 = 1'b1; #1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1 v0 = ((c >= 5 && c <= 7) || c == 20); f0 = (c == 20); #1;
      if (c == 10) begin
        n_checks++;
        if (pend0 !== PW0'(3)) $display("FAIL flush_pre got=%0d want=3", pend0); else n_pass++;
      end
      if (c == 20) begin
        n_checks++;
        if (ready0 !== 1'b0) $display("FAIL flush_ready got=%b want=0", ready0); else n_pass++;
      end
      if (c == 21) begin
        n_checks++;
        if (pend0 !== PW0'(0)) $display("FAIL flush_pend got=%0d want=0", pend0); else n_pass++;
      end
      if (bend0 && bend_c < 0) bend_c = c;
    end
    n_checks++;
    if (bend_c != 98) $display("FAIL flush_bend got=%0d want=98", bend_c); else n_pass++;
    n_checks++;
    if (pulses0 - p != 64) $display("FAIL flush_pulses got=%0d want=64", pulses0 - p); else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    int p;
    @(posedge clk); #1 v0 = 1'b1; #1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1 v0 = 1'b0; #1;
    end
    n_checks++;
    if ({idx0, txck0} !== {CW0'(20), 1'b1}) $display("FAIL rstmid_pre got idx=%0d ck=%b want 20/1", idx0, txck0);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready0, busy0, ser0, done0, bend0, txck0, idx0, pend0} !== {6'b100000, CW0'(0), PW0'(0)})
      $display("FAIL rstmid_async got=%b idx=%0d want ready=1 rest 0",
               {ready0, busy0, ser0, done0, bend0, txck0}, idx0);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    p = pulses0;
    @(posedge clk); #1 v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (110) @(posedge clk);
    #2;
    n_checks++;
    if (pulses0 - p != 64) $display("FAIL rstmid_after got=%0d want=64", pulses0 - p); else n_pass++;
  endtask

  task automatic test_param_sweep();
    int p, acc, r;
    time first_t, last_t;
    p = pulses1; acc = 0; first_t = 0; last_t = 0;
    r = runts1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1 v1 = (acc < 3); #1;
      if (v1 && ready1) acc++;
      if (txck1) begin
        if (first_t == 0) first_t = $time;
        last_t = $time;
      end
    end
    #1 v1 = 1'b0;
    n_checks++;
    if (acc != 3) $display("FAIL sweep_accepts got=%0d want=3", acc); else n_pass++;
    n_checks++;
    if (pulses1 - p != 24) $display("FAIL sweep_pulses got=%0d want=24", pulses1 - p); else n_pass++;
    n_checks++;
    if (last_t - first_t != 250) $display("FAIL sweep_span got=%0t want=250", last_t - first_t); else n_pass++;
    n_checks++;
    if (runts1 != r) $display("FAIL sweep_runts got=%0d want=%0d", runts1, r); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      v0 = ($urandom_range(0, 99) < 40);
      f0 = ($urandom_range(0, 99) < 2);
      v1 = ($urandom_range(0, 99) < 50);
      f1 = ($urandom_range(0, 99) < 3);
    end
    @(posedge clk); #1 v0 = 1'b0; f0 = 1'b0; v1 = 1'b0; f1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #2;
      if (!busy0 && !busy1) break;
    end
    n_checks++;
    if ({busy0, busy1} !== 2'b00) $display("FAIL random_drain got=%b want=00", {busy0, busy1}); else n_pass++;
    n_checks++;
    if (runts0 != 0 || runts1 != 0) $display("FAIL runts got=%0d/%0d want=0/0", runts0, runts1); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    repeat (3) @(posedge clk);
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_full_queue();
    test_flush();
    repeat (3) @(posedge clk);
    test_reset_mid_send();
    test_param_sweep();
    test_random();
    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
